// File: rtl/fsmc_pkg.sv
// Shared types and constants for the FSMC-to-register-bus bridge.
package fsmc_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2
  } rd_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int RD_LAT_DEF  = 2;
  localparam int TO_CYC_DEF  = 255;
endpackage

// File: rtl/sync_pipe.sv
// Multi-stage register pipeline with synchronous reset to a configurable idle value.
module sync_pipe
  import fsmc_pkg::*;
#(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [W-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[SYNC_STAGES-1];
endmodule

// File: rtl/fsmc_bridge.sv
// Async FSMC/NOR bus to synchronous register bus bridge: resynchronised pins,
// single-cycle writes, fixed-latency reads with NWAIT, sticky error flag.
module fsmc_bridge
  import fsmc_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic        fsmc_ne,
  input  logic        fsmc_noe,
  input  logic        fsmc_nwe,
  input  logic [1:0]  fsmc_nbl,
  input  logic [15:0] fsmc_a,
  input  logic [15:0] fsmc_d_in,
  output logic [15:0] fsmc_d_out,
  output logic        fsmc_d_oe,
  output logic        fsmc_nwait,
  output logic [15:0] rdaddr,
  output logic [15:0] wraddr,
  output logic [1:0]  be,
  output logic        write,
  output logic [15:0] wrdata,
  input  logic [15:0] rddata,
  output logic        bus_err,
  input  logic        bus_err_clr
);
  localparam int CW = $clog2(TO_CYC + 1);
  localparam int PW = 37;

  logic [PW-1:0] pins, spins;
  logic          s_ne, s_noe, s_nwe;
  logic [1:0]    s_nbl;
  logic [15:0]   s_a, s_d;

  assign pins = {fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_nbl, fsmc_a, fsmc_d_in};

  sync_pipe #(
    .W       (PW),
    .RST_VAL ({3'b111, 2'b11, 16'h0000, 16'h0000})
  ) u_sync (
    .clk  (clk),
    .sclr (sclr),
    .din  (pins),
    .dout (spins)
  );

  assign {s_ne, s_noe, s_nwe, s_nbl, s_a, s_d} = spins;

  rd_state_t     state;
  logic [CW-1:0] cnt;
  logic          prev_noe, prev_nwe;
  logic [1:0]    settle_cnt;
  logic          noe_armed, nwe_armed;
  logic [15:0]   hold_a, hold_d;
  logic [1:0]    hold_be;
  logic          wr_pend, wr_abort, wr_fire;
  logic          settled, noe_fall, nwe_rise, proto_err, timeout;

  // Edges only count once the pipeline holds real pin values and the strobe
  // has been seen high, so a strobe held low through reset is ignored.
  assign settled   = (settle_cnt == 2'(SYNC_STAGES));
  assign noe_fall  = noe_armed & prev_noe & ~s_noe;
  assign nwe_rise  = nwe_armed & ~prev_nwe & s_nwe;
  assign proto_err = ~s_noe & ~s_nwe;
  assign timeout   = (state != IDLE) && (cnt == CW'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (sclr) begin
      prev_noe   <= 1'b1;
      prev_nwe   <= 1'b1;
      settle_cnt <= 2'd0;
      noe_armed  <= 1'b0;
      nwe_armed  <= 1'b0;
    end else begin
      prev_noe <= s_noe;
      prev_nwe <= s_nwe;
      if (!settled) settle_cnt <= settle_cnt + 2'd1;
      if (settled && s_noe) noe_armed <= 1'b1;
      if (settled && s_nwe) nwe_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state      <= IDLE;
      cnt        <= '0;
      rdaddr     <= 16'h0000;
      fsmc_d_out <= 16'h0000;
      fsmc_d_oe  <= 1'b0;
      fsmc_nwait <= 1'b1;
    end else if (proto_err || timeout) begin
      state      <= IDLE;
      fsmc_d_oe  <= 1'b0;
      fsmc_nwait <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (noe_fall && !s_ne && s_nwe) begin
            rdaddr     <= s_a;
            cnt        <= '0;
            fsmc_nwait <= 1'b0;
            state      <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(RD_LAT)) begin
            fsmc_d_out <= rddata;
            fsmc_d_oe  <= 1'b1;
            fsmc_nwait <= 1'b1;
            state      <= RD_DRIVE;
          end
        end
        RD_DRIVE: begin
          cnt <= cnt + CW'(1);
          if (s_noe || s_ne) begin
            fsmc_d_oe <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          fsmc_d_oe  <= 1'b0;
          fsmc_nwait <= 1'b1;
        end
      endcase
    end
  end

  // Write address/data load on the detected rising edge; the strobe follows a
  // cycle later so the holding registers are free for a back-to-back write.
  always_ff @(posedge clk) begin
    if (sclr) begin
      hold_a   <= 16'h0000;
      hold_d   <= 16'h0000;
      hold_be  <= 2'b00;
      wr_pend  <= 1'b0;
      wr_abort <= 1'b0;
      wr_fire  <= 1'b0;
      write    <= 1'b0;
      wraddr   <= 16'h0000;
      wrdata   <= 16'h0000;
      be       <= 2'b00;
    end else begin
      write   <= wr_fire;
      wr_fire <= 1'b0;
      if (proto_err) begin
        wr_pend  <= 1'b0;
        wr_abort <= 1'b1;
      end else begin
        if (s_nwe) wr_abort <= 1'b0;
        if (!s_ne && !s_nwe && nwe_armed && !wr_abort) begin
          hold_a  <= s_a;
          hold_d  <= s_d;
          hold_be <= ~s_nbl;
          wr_pend <= 1'b1;
        end
        if (nwe_rise && wr_pend && (state == IDLE)) begin
          wraddr  <= hold_a;
          wrdata  <= hold_d;
          be      <= hold_be;
          wr_fire <= 1'b1;
          wr_pend <= 1'b0;
        end else if (nwe_rise) begin
          wr_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      bus_err <= 1'b0;
    end else if (proto_err || timeout) begin
      bus_err <= 1'b1;
    end else if (bus_err_clr) begin
      bus_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fsmc_bridge.sv
// Directed self-checking bench for fsmc_bridge with a two-register decoder model.
module tb_fsmc_bridge;
  logic        clk = 1'b0;
  logic        sclr;
  logic        fsmc_ne, fsmc_noe, fsmc_nwe;
  logic [1:0]  fsmc_nbl;
  logic [15:0] fsmc_a, fsmc_d_in, fsmc_d_out;
  logic        fsmc_d_oe, fsmc_nwait;
  logic [15:0] rdaddr, wraddr, wrdata, rddata;
  logic [1:0]  be;
  logic        write, bus_err, bus_err_clr;

  int vectors = 0;
  int errors  = 0;
  int wr_pulses = 0;
  int snap;
  logic [15:0] dec_r1 = 16'h0000;

  fsmc_bridge dut (
    .clk(clk), .sclr(sclr),
    .fsmc_ne(fsmc_ne), .fsmc_noe(fsmc_noe), .fsmc_nwe(fsmc_nwe),
    .fsmc_nbl(fsmc_nbl), .fsmc_a(fsmc_a), .fsmc_d_in(fsmc_d_in),
    .fsmc_d_out(fsmc_d_out), .fsmc_d_oe(fsmc_d_oe), .fsmc_nwait(fsmc_nwait),
    .rdaddr(rdaddr), .wraddr(wraddr), .be(be), .write(write), .wrdata(wrdata),
    .rddata(rddata), .bus_err(bus_err), .bus_err_clr(bus_err_clr)
  );

  always #5 clk = ~clk;

  // Decoder: output register plus sub-block register, 2 cycles from rdaddr.
  initial rddata = 16'h0000;
  always @(posedge clk) begin
    dec_r1 <= (rdaddr == 16'h01C0) ? 16'h1234 : ~rdaddr;
    rddata <= dec_r1;
  end

  always @(negedge clk) if (write === 1'b1) wr_pulses++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    sclr = 1'b1; bus_err_clr = 1'b0;
    fsmc_ne = 1'b1; fsmc_noe = 1'b1; fsmc_nwe = 1'b1;
    fsmc_nbl = 2'b11; fsmc_a = 16'h0000; fsmc_d_in = 16'h0000;
    step(3);
    chk("rst_d_oe",  {15'd0, fsmc_d_oe},  16'h0000);
    chk("rst_nwait", {15'd0, fsmc_nwait}, 16'h0001);
    chk("rst_write", {15'd0, write},      16'h0000);
    chk("rst_err",   {15'd0, bus_err},    16'h0000);
    chk("rst_rdaddr", rdaddr, 16'h0000);
    chk("rst_wraddr", wraddr, 16'h0000);
    chk("rst_dout",   fsmc_d_out, 16'h0000);
    sclr = 1'b0;
    step(5);

    // Full-word write
    snap = wr_pulses;
    fsmc_ne = 1'b0; fsmc_a = 16'h0181; fsmc_d_in = 16'hA5C3; fsmc_nbl = 2'b00; fsmc_nwe = 1'b0;
    step(4);
    fsmc_nwe = 1'b1;
    step(3);
    chk("wr_early", {15'd0, write}, 16'h0000);
    step(1);
    chk("wr_pulse", {15'd0, write}, 16'h0001);
    chk("wr_addr", wraddr, 16'h0181);
    chk("wr_data", wrdata, 16'hA5C3);
    chk("wr_be", {14'd0, be}, 16'h0003);
    step(1);
    chk("wr_single", {15'd0, write}, 16'h0000);
    step(2);
    chk("wr_count", 16'(wr_pulses - snap), 16'h0001);

    // Byte write followed back-to-back by a second write after one NWE-high cycle
    snap = wr_pulses;
    fsmc_a = 16'h0042; fsmc_d_in = 16'h5A0F; fsmc_nbl = 2'b10; fsmc_nwe = 1'b0;
    step(2);
    fsmc_nwe = 1'b1;
    step(1);
    fsmc_a = 16'h0043; fsmc_d_in = 16'h1111; fsmc_nbl = 2'b01; fsmc_nwe = 1'b0;
    step(2);
    fsmc_nwe = 1'b1;
    step(1);
    chk("bw_pulse", {15'd0, write}, 16'h0001);
    chk("bw_addr", wraddr, 16'h0042);
    chk("bw_data", wrdata, 16'h5A0F);
    chk("bw_be", {14'd0, be}, 16'h0001);
    step(3);
    chk("b2b_pulse", {15'd0, write}, 16'h0001);
    chk("b2b_addr", wraddr, 16'h0043);
    chk("b2b_data", wrdata, 16'h1111);
    chk("b2b_be", {14'd0, be}, 16'h0002);
    step(3);
    chk("b2b_count", 16'(wr_pulses - snap), 16'h0002);
    fsmc_ne = 1'b1;
    step(3);

    // Read with decoder latency
    fsmc_ne = 1'b0; fsmc_a = 16'h01C0; fsmc_noe = 1'b0;
    step(2);
    chk("rd_nwait_pre", {15'd0, fsmc_nwait}, 16'h0001);
    step(1);
    chk("rd_addr", rdaddr, 16'h01C0);
    chk("rd_nwait3", {15'd0, fsmc_nwait}, 16'h0000);
    step(2);
    chk("rd_nwait5", {15'd0, fsmc_nwait}, 16'h0000);
    chk("rd_oe5", {15'd0, fsmc_d_oe}, 16'h0000);
    step(1);
    chk("rd_data", fsmc_d_out, 16'h1234);
    chk("rd_oe6", {15'd0, fsmc_d_oe}, 16'h0001);
    chk("rd_nwait6", {15'd0, fsmc_nwait}, 16'h0001);
    step(3);
    fsmc_noe = 1'b1;
    step(2);
    chk("rd_hold", {15'd0, fsmc_d_oe}, 16'h0001);
    step(1);
    chk("rd_release", {15'd0, fsmc_d_oe}, 16'h0000);
    fsmc_ne = 1'b1;
    step(3);

    // Read timeout with NOE held low for 300 cycles
    fsmc_ne = 1'b0; fsmc_a = 16'h0300; fsmc_noe = 1'b0;
    step(6);
    chk("to_data", fsmc_d_out, 16'hFCFF);
    step(251);
    chk("to_oe_before", {15'd0, fsmc_d_oe}, 16'h0001);
    chk("to_err_before", {15'd0, bus_err}, 16'h0000);
    step(1);
    chk("to_oe", {15'd0, fsmc_d_oe}, 16'h0000);
    chk("to_nwait", {15'd0, fsmc_nwait}, 16'h0001);
    chk("to_err", {15'd0, bus_err}, 16'h0001);
    step(10);
    chk("to_no_rearm", {15'd0, fsmc_nwait}, 16'h0001);
    step(32);
    fsmc_noe = 1'b1; fsmc_ne = 1'b1;
    step(3);
    bus_err_clr = 1'b1;
    step(1);
    bus_err_clr = 1'b0;
    chk("clr_err", {15'd0, bus_err}, 16'h0000);

    // Protocol error with clear held: set wins, no write, bus released
    snap = wr_pulses;
    bus_err_clr = 1'b1;
    fsmc_ne = 1'b0; fsmc_a = 16'h0055; fsmc_d_in = 16'hBEEF; fsmc_nbl = 2'b00;
    fsmc_nwe = 1'b0; fsmc_noe = 1'b0;
    step(3);
    chk("pe_err", {15'd0, bus_err}, 16'h0001);
    chk("pe_oe", {15'd0, fsmc_d_oe}, 16'h0000);
    chk("pe_nwait", {15'd0, fsmc_nwait}, 16'h0001);
    bus_err_clr = 1'b0;
    step(2);
    fsmc_nwe = 1'b1; fsmc_noe = 1'b1;
    step(6);
    chk("pe_no_write", 16'(wr_pulses - snap), 16'h0000);
    chk("pe_sticky", {15'd0, bus_err}, 16'h0001);
    fsmc_ne = 1'b1;
    bus_err_clr = 1'b1;
    step(1);
    bus_err_clr = 1'b0;
    chk("pe_clr", {15'd0, bus_err}, 16'h0000);
    step(2);

    // Reset during RD_DRIVE, NOE held low across reset
    fsmc_ne = 1'b0; fsmc_a = 16'h01C0; fsmc_noe = 1'b0;
    step(7);
    chk("rr_drive", {15'd0, fsmc_d_oe}, 16'h0001);
    sclr = 1'b1;
    step(1);
    chk("rr_oe", {15'd0, fsmc_d_oe}, 16'h0000);
    chk("rr_nwait", {15'd0, fsmc_nwait}, 16'h0001);
    sclr = 1'b0;
    step(10);
    chk("rr_no_read", rdaddr, 16'h0000);
    chk("rr_nwait_idle", {15'd0, fsmc_nwait}, 16'h0001);
    fsmc_noe = 1'b1;
    step(4);
    fsmc_noe = 1'b0;
    step(3);
    chk("rr_new_addr", rdaddr, 16'h01C0);
    step(3);
    chk("rr_new_data", fsmc_d_out, 16'h1234);
    chk("rr_new_oe", {15'd0, fsmc_d_oe}, 16'h0001);
    fsmc_noe = 1'b1; fsmc_ne = 1'b1;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
